// File: rtl/isolde_exec_responder.sv
// Execute-side responder for the ISOLDE fetch-to-exec handshake: captures a decoded request,
// fetches GPR operands over one read port, offers the job, and grants. Option: ISOLDE_EXEC_BLOCKING_EN.
module isolde_exec_responder #(
   parameter int OPC_W          = 5,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               exec_req_i,
   input  logic               illegal_i,
   input  logic [OPC_W-1:0]   opcode_i,
   input  logic [2:0]         func3_i,
   input  logic [1:0]         funct2_i,
   input  logic [31:0]        instr_i,
   input  logic [127:0]       imm32_i,
   input  logic [3:0]         imm32_valid_i,
   input  logic [19:0]        raddr_i,
   input  logic [3:0]         raddr_vld_i,
   output logic               exec_gnt_o,
   output logic [4:0]         rf_raddr_o,
   input  logic [31:0]        rf_rdata_i,
   output logic               job_valid_o,
   input  logic               job_ready_i,
   output logic [OPC_W-1:0]   job_opcode_o,
   output logic [4:0]         job_ctrl_o,
   output logic [31:0]        job_instr_o,
   output logic [127:0]       job_ops_o,
   output logic [127:0]       job_imm_o,
   input  logic               done_i,
   output logic               busy_o,
   output logic               err_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_GRANT = 3'd4;

   logic [2:0]       r_state;
   logic [OPC_W-1:0] r_opcode;
   logic [4:0]       r_ctrl;
   logic [31:0]      r_instr;
   logic [127:0]     r_imm;
   logic [127:0]     r_ops;
   logic [19:0]      r_raddr;
   logic [3:0]       r_remain;
   logic             r_pend;
   logic [1:0]       r_pendIdx;
   logic             r_illPulse;

   logic [1:0]       w_selIdx;
   logic             w_selVld;
   logic [4:0]       w_rfAddr;
   logic [127:0]     w_immMasked;
   logic             w_toErr;

   // Lowest pending read slot; the descending loop lets the smallest index win.
   always_comb begin
      w_selIdx = 2'd0;
      w_selVld = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (r_remain[i]) begin
            w_selIdx = 2'(i);
            w_selVld = 1'b1;
         end
      end
   end

   always_comb begin
      w_rfAddr = 5'd0;
      for (int i = 0; i < 4; i++) begin
         if (w_selIdx == 2'(i)) w_rfAddr = r_raddr[i*5 +: 5];
      end
   end

   always_comb begin
      w_immMasked = '0;
      for (int i = 0; i < 4; i++) begin
         if (imm32_valid_i[i]) w_immMasked[i*32 +: 32] = imm32_i[i*32 +: 32];
      end
   end

`ifdef ISOLDE_EXEC_BLOCKING_EN
   localparam int         CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_timeout;

   // The timeout fires in the cycle the counter would step onto TIMEOUT_CYCLES, so the
   // error pulse is seen while still in WAIT_DONE and the grant follows one cycle later.
   assign w_timeout = TO_EN && (r_state == S_WAIT) && (r_cnt == TO_LAST);
   assign w_toErr   = w_timeout && !done_i;
`else
   logic w_unusedDone;
   assign w_unusedDone = done_i;
   assign w_toErr      = 1'b0;
`endif

   // Main FSM with the payload registers; reset aborts any job outright.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_opcode   <= '0;
         r_ctrl     <= '0;
         r_instr    <= '0;
         r_imm      <= '0;
         r_ops      <= '0;
         r_raddr    <= '0;
         r_remain   <= '0;
         r_pend     <= 1'b0;
         r_pendIdx  <= '0;
         r_illPulse <= 1'b0;
`ifdef ISOLDE_EXEC_BLOCKING_EN
         r_cnt      <= '0;
`endif
      end else begin
         r_illPulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (exec_req_i) begin
                  if (illegal_i) begin
                     r_illPulse <= 1'b1;
                  end else begin
                     r_opcode <= opcode_i;
                     r_ctrl   <= {funct2_i, func3_i};
                     r_instr  <= instr_i;
                     r_imm    <= w_immMasked;
                     r_ops    <= '0;
                     r_raddr  <= raddr_i;
                     r_remain <= raddr_vld_i;
                     r_pend   <= 1'b0;
                     r_state  <= (|raddr_vld_i) ? S_READ : S_ISSUE;
                  end
               end
            end
            S_READ: begin
               if (r_pend) begin
                  for (int i = 0; i < 4; i++) begin
                     if (r_pendIdx == 2'(i)) r_ops[i*32 +: 32] <= rf_rdata_i;
                  end
               end
               if (w_selVld) begin
                  r_remain[w_selIdx] <= 1'b0;
                  r_pend             <= 1'b1;
                  r_pendIdx          <= w_selIdx;
               end else begin
                  r_pend  <= 1'b0;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (job_ready_i) begin
`ifdef ISOLDE_EXEC_BLOCKING_EN
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
`else
                  r_state <= S_GRANT;
`endif
               end
            end
`ifdef ISOLDE_EXEC_BLOCKING_EN
            S_WAIT: begin
               if (done_i || w_timeout) begin
                  r_state <= S_GRANT;
               end else if (r_cnt != {CNT_W{1'b1}}) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_GRANT: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rf_raddr_o   = ((r_state == S_READ) && w_selVld) ? w_rfAddr : 5'd0;
   assign job_valid_o  = (r_state == S_ISSUE);
   assign job_opcode_o = r_opcode;
   assign job_ctrl_o   = r_ctrl;
   assign job_instr_o  = r_instr;
   assign job_ops_o    = r_ops;
   assign job_imm_o    = r_imm;
   assign busy_o       = (r_state != S_IDLE);
   assign exec_gnt_o   = (r_state == S_GRANT) || r_illPulse;
   assign err_o        = r_illPulse || w_toErr;

endmodule

// File: tb/tb_isolde_exec_responder.sv
// Directed self-checking bench for isolde_exec_responder; blocking-mode scenarios build
// only when ISOLDE_EXEC_BLOCKING_EN is defined.
module tb_isolde_exec_responder;

   logic         clk;
   logic         rst;
   logic         execReq;
   logic         illegal;
   logic [4:0]   opcode;
   logic [2:0]   func3;
   logic [1:0]   funct2;
   logic [31:0]  instr;
   logic [127:0] imm32;
   logic [3:0]   immValid;
   logic [19:0]  raddr;
   logic [3:0]   raddrVld;
   logic         execGnt;
   logic [4:0]   rfRaddr;
   logic [31:0]  rfRdata;
   logic         jobValid;
   logic         jobReady;
   logic [4:0]   jobOpcode;
   logic [4:0]   jobCtrl;
   logic [31:0]  jobInstr;
   logic [127:0] jobOps;
   logic [127:0] jobImm;
   logic         done;
   logic         busy;
   logic         err;

   int checks = 0;
   int errors = 0;

   isolde_exec_responder #(.OPC_W(5), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_i(rst), .exec_req_i(execReq), .illegal_i(illegal),
      .opcode_i(opcode), .func3_i(func3), .funct2_i(funct2), .instr_i(instr),
      .imm32_i(imm32), .imm32_valid_i(immValid), .raddr_i(raddr), .raddr_vld_i(raddrVld),
      .exec_gnt_o(execGnt), .rf_raddr_o(rfRaddr), .rf_rdata_i(rfRdata),
      .job_valid_o(jobValid), .job_ready_i(jobReady), .job_opcode_o(jobOpcode),
      .job_ctrl_o(jobCtrl), .job_instr_o(jobInstr), .job_ops_o(jobOps), .job_imm_o(jobImm),
      .done_i(done), .busy_o(busy), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: data appears one cycle after the address.
   always @(posedge clk) begin
      if (rfRaddr == 5'd3)      rfRdata <= 32'h0000_0011;
      else if (rfRaddr == 5'd7) rfRdata <= 32'h0000_0022;
      else                      rfRdata <= 32'hBAD0_0000 | {27'd0, rfRaddr};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      execReq = 0; illegal = 0; opcode = 0; func3 = 0; funct2 = 0; instr = 0;
      imm32 = 0; immValid = 0; raddr = 0; raddrVld = 0; jobReady = 0; done = 0;
   endtask

   // Called on the first cycle after a handshake; in blocking builds it supplies completion.
   task automatic completeJob();
`ifdef ISOLDE_EXEC_BLOCKING_EN
      done = 1;
      tick();
      done = 0;
`endif
   endtask

   task automatic test_reset();
      clearInputs();
      rst = 1;
      tick();
      tick();
      checks++; if (execGnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b want 0", execGnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
      checks++; if (jobValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", jobValid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (rfRaddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_raddr got %0d want 0", rfRaddr); end
      checks++; if ({jobOpcode, jobCtrl, jobInstr, jobOps, jobImm} !== '0) begin errors++; $display("[TB] FAIL reset_payload got nonzero want 0"); end
      rst = 0;
   endtask

   task automatic test_illegal();
      execReq = 1; illegal = 1; opcode = 5'h1F; instr = 32'h1234_5678;
      tick();
      execReq = 0; illegal = 0;
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %b want 1", err); end
      checks++; if (execGnt !== 1'b1) begin errors++; $display("[TB] FAIL illegal_gnt got %b want 1", execGnt); end
      checks++; if (jobValid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_valid got %b want 0", jobValid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy got %b want 0", busy); end
      tick();
      checks++; if ({err, execGnt, jobValid} !== 3'b000) begin errors++; $display("[TB] FAIL illegal_after got %b want 000", {err, execGnt, jobValid}); end
      checks++; if (jobOpcode !== 5'h00) begin errors++; $display("[TB] FAIL illegal_nocapture got %h want 00", jobOpcode); end
   endtask

   task automatic test_read_ops();
      clearInputs();
      execReq = 1; opcode = 5'h0B; func3 = 3'b101; funct2 = 2'b10; instr = 32'hDEAD_BEEF;
      imm32 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      immValid = 4'b0111;
      raddr = {5'd12, 5'd7, 5'd9, 5'd3};
      raddrVld = 4'b0101;
      jobReady = 1;
      tick();
      clearInputs();
      jobReady = 1;
      checks++; if (rfRaddr !== 5'd3) begin errors++; $display("[TB] FAIL read_addr0 got %0d want 3", rfRaddr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy got %b want 1", busy); end
      tick();
      checks++; if (rfRaddr !== 5'd7) begin errors++; $display("[TB] FAIL read_addr1 got %0d want 7", rfRaddr); end
      tick();
      checks++; if (jobValid !== 1'b0) begin errors++; $display("[TB] FAIL read_lastcap_valid got %b want 0", jobValid); end
      tick();
      checks++; if (jobValid !== 1'b1) begin errors++; $display("[TB] FAIL read_issue_valid got %b want 1", jobValid); end
      checks++; if (jobOps !== {32'h0, 32'h22, 32'h0, 32'h11}) begin errors++; $display("[TB] FAIL read_ops got %h want %h", jobOps, {32'h0, 32'h22, 32'h0, 32'h11}); end
      checks++; if (jobImm !== {32'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}) begin errors++; $display("[TB] FAIL read_imm got %h", jobImm); end
      checks++; if (jobCtrl !== 5'b10101) begin errors++; $display("[TB] FAIL read_ctrl got %b want 10101", jobCtrl); end
      checks++; if ({jobOpcode, jobInstr} !== {5'h0B, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL read_opinstr got %h %h want 0b deadbeef", jobOpcode, jobInstr); end
      tick();
      completeJob();
      checks++; if (execGnt !== 1'b1) begin errors++; $display("[TB] FAIL read_gnt got %b want 1", execGnt); end
      checks++; if (jobValid !== 1'b0) begin errors++; $display("[TB] FAIL read_valid_drop got %b want 0", jobValid); end
      tick();
      checks++; if ({busy, execGnt} !== 2'b00) begin errors++; $display("[TB] FAIL read_idle got %b want 00", {busy, execGnt}); end
      checks++; if (jobOps !== {32'h0, 32'h22, 32'h0, 32'h11}) begin errors++; $display("[TB] FAIL read_retain got %h", jobOps); end
      jobReady = 0;
   endtask

   task automatic test_stall();
      clearInputs();
      execReq = 1; opcode = 5'h15; instr = 32'hCAFE_F00D;
      tick();
      clearInputs();
      for (int k = 0; k < 5; k++) begin
         checks++; if (jobValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid_%0d got %b want 1", k, jobValid); end
         checks++; if ({jobOpcode, jobInstr} !== {5'h15, 32'hCAFE_F00D}) begin errors++; $display("[TB] FAIL stall_payload_%0d got %h %h", k, jobOpcode, jobInstr); end
         checks++; if (execGnt !== 1'b0) begin errors++; $display("[TB] FAIL stall_gnt_%0d got %b want 0", k, execGnt); end
         execReq = (k == 1); opcode = 5'h07; instr = 32'h0;
         tick();
      end
      execReq = 0;
      jobReady = 1;
      checks++; if (jobValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hs_valid got %b want 1", jobValid); end
      tick();
      jobReady = 0;
      completeJob();
      checks++; if (execGnt !== 1'b1) begin errors++; $display("[TB] FAIL stall_gnt got %b want 1", execGnt); end
      checks++; if (jobOpcode !== 5'h15) begin errors++; $display("[TB] FAIL stall_ignored got %h want 15", jobOpcode); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_read();
      clearInputs();
      execReq = 1; opcode = 5'h03; raddr = {5'd4, 5'd3, 5'd2, 5'd1}; raddrVld = 4'b1111;
      imm32 = {4{32'hAAAA_5555}}; immValid = 4'b1111;
      tick();
      clearInputs();
      checks++; if (rfRaddr !== 5'd1) begin errors++; $display("[TB] FAIL rstmid_addr0 got %0d want 1", rfRaddr); end
      tick();
      checks++; if (rfRaddr !== 5'd2) begin errors++; $display("[TB] FAIL rstmid_addr1 got %0d want 2", rfRaddr); end
      rst = 1;
      tick();
      rst = 0;
      checks++; if ({busy, jobValid, execGnt, err, rfRaddr} !== 9'd0) begin errors++; $display("[TB] FAIL rstmid_ctrl got %b want 0", {busy, jobValid, execGnt, err, rfRaddr}); end
      checks++; if ({jobOpcode, jobOps, jobImm} !== '0) begin errors++; $display("[TB] FAIL rstmid_payload got nonzero want 0"); end
      execReq = 1; opcode = 5'h09; jobReady = 1;
      tick();
      execReq = 0;
      checks++; if ({jobValid, jobOpcode} !== {1'b1, 5'h09}) begin errors++; $display("[TB] FAIL rstmid_resume got %b %h want 1 09", jobValid, jobOpcode); end
      tick();
      jobReady = 0;
      completeJob();
      checks++; if (execGnt !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_gnt got %b want 1", execGnt); end
      tick();
   endtask

`ifdef ISOLDE_EXEC_BLOCKING_EN
   task automatic test_timeout(input logic doneAtTimeout);
      clearInputs();
      execReq = 1; opcode = 5'h11; jobReady = 1;
      tick();
      execReq = 0;
      checks++; if (jobValid !== 1'b1) begin errors++; $display("[TB] FAIL to_valid got %b want 1", jobValid); end
      tick();
      jobReady = 0;
      for (int k = 1; k < 8; k++) begin
         checks++; if ({busy, err, execGnt} !== 3'b100) begin errors++; $display("[TB] FAIL to_wait_%0d got %b want 100", k, {busy, err, execGnt}); end
         tick();
      end
      done = doneAtTimeout;
      #1;
      checks++; if (err !== !doneAtTimeout) begin errors++; $display("[TB] FAIL to_err got %b want %b", err, !doneAtTimeout); end
      checks++; if (execGnt !== 1'b0) begin errors++; $display("[TB] FAIL to_early_gnt got %b want 0", execGnt); end
      tick();
      done = 0;
      checks++; if ({execGnt, err} !== 2'b10) begin errors++; $display("[TB] FAIL to_gnt got %b want 10", {execGnt, err}); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle got %b want 0", busy); end
   endtask
`else
   task automatic test_latency();
      clearInputs();
      execReq = 1; opcode = 5'h02; jobReady = 1;
      tick();
      execReq = 0;
      checks++; if ({jobValid, execGnt} !== 2'b10) begin errors++; $display("[TB] FAIL lat_c1 got %b want 10", {jobValid, execGnt}); end
      tick();
      checks++; if ({jobValid, execGnt} !== 2'b01) begin errors++; $display("[TB] FAIL lat_c2 got %b want 01", {jobValid, execGnt}); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL lat_err got %b want 0", err); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL lat_c3 got %b want 0", busy); end
      jobReady = 0;
   endtask
`endif

   initial begin
      rst = 1;
      clearInputs();
      #1;
      test_reset();
      test_illegal();
      test_read_ops();
      test_stall();
      test_reset_mid_read();
`ifdef ISOLDE_EXEC_BLOCKING_EN
      test_timeout(1'b0);
      test_timeout(1'b1);
`else
      test_latency();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
